// File: rtl/pwm_fade_ctrl.sv
// -----------------------------------------------------------------------------
// pwm_fade_ctrl
//
// Fade controller for a bank of PWM channels. A free-running prescaler emits a
// one-clock step strobe every PRESCALE clocks. Each channel runs a small
// IDLE/RAMP state machine. A command moves the channel's duty value one code
// at a time toward a target. The duty value moves once every (rate + 1) step
// strobes. When the target is reached, a one-clock done pulse is issued.
//
// Optional build macro: PWM_FADE_STATUS_EN
//   When defined, adds irq_clr/irq. Each channel has a sticky flag that is set
//   by that channel's done pulse and cleared by irq_clr. If both happen on the
//   same edge, the set wins. irq is the OR of all flags.
//
// Ports
//   clk         single clock, rising edge
//   rst         asynchronous, active-low reset
//   ena_in      global run enable (0 freezes ramps, holds prescaler at 0)
//   cmd_valid   command request
//   cmd_ready   command accept (combinational from cmd_ch and busy)
//   cmd_ch      target channel; values >= CH are accepted and dropped
//   cmd_target  final duty value
//   cmd_rate    extra step strobes between duty increments (0 = fastest)
//   step        one-clock strobe for the pwm blocks
//   ena         per-channel pwm enable (mirrors ena_in outside reset)
//   duty        packed duty values, channel i at [i*N +: N]
//   busy        channel is ramping
//   done        one-clock pulse when a channel reaches its target
//   irq_clr     (PWM_FADE_STATUS_EN only) clear all sticky done flags
//   irq         (PWM_FADE_STATUS_EN only) OR of sticky done flags
// -----------------------------------------------------------------------------
module pwm_fade_ctrl #(
  parameter int N        = 8,
  parameter int CH       = 3,
  parameter int PRESCALE = 256,
  parameter int RATE_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena_in,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_ch,
  input  logic [N-1:0]      cmd_target,
  input  logic [RATE_W-1:0] cmd_rate,
  output logic              step,
  output logic [CH-1:0]     ena,
  output logic [CH*N-1:0]   duty,
  output logic [CH-1:0]     busy,
  output logic [CH-1:0]     done
`ifdef PWM_FADE_STATUS_EN
  ,
  input  logic              irq_clr,
  output logic              irq
`endif
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  localparam int PS_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

  // ---------------------------------------------------------------------------
  // Prescaler: counts while enabled, forced back to 0 while disabled.
  // ---------------------------------------------------------------------------
  logic [PS_W-1:0] ps_cnt_reg;
  logic [PS_W-1:0] ps_cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_cnt_reg <= '0;
    end else begin
      ps_cnt_reg <= ps_cnt_next;
    end
  end

  always_comb begin
    ps_cnt_next = '0;
    if (ena_in && (ps_cnt_reg != PS_MAX)) begin
      ps_cnt_next = ps_cnt_reg + 1'b1;
    end
  end

  // The counter is 0 in reset, and PS_MAX is never 0, so step is low in reset.
  assign step = ena_in & (ps_cnt_reg == PS_MAX);

  // ena follows ena_in but is forced low while reset is held.
  assign ena  = rst ? {CH{ena_in}} : '0;

  // ---------------------------------------------------------------------------
  // Command handshake. busy is padded to the full 2-bit channel space, so that
  // indexing with an out-of-range cmd_ch stays within bounds.
  // ---------------------------------------------------------------------------
  logic [3:0] busy_pad;
  logic       cmd_ch_ok;
  logic       cmd_fire;

  assign busy_pad  = 4'(busy);
  assign cmd_ch_ok = ({1'b0, cmd_ch} < 3'(CH));
  assign cmd_ready = cmd_ch_ok ? ~busy_pad[cmd_ch] : 1'b1;
  assign cmd_fire  = cmd_valid & cmd_ready;

  // ---------------------------------------------------------------------------
  // Per-channel ramp engines
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi = gi + 1) begin : g_ch
      state_t            state_reg,  state_next;
      logic [N-1:0]      duty_reg,   duty_next;
      logic [N-1:0]      target_reg, target_next;
      logic [RATE_W-1:0] rate_reg,   rate_next;
      logic [RATE_W-1:0] rcnt_reg,   rcnt_next;
      logic              done_reg,   done_next;
      logic              sel;

      assign sel = cmd_fire && (cmd_ch == 2'(gi));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg  <= S_IDLE;
          duty_reg   <= '0;
          target_reg <= '0;
          rate_reg   <= '0;
          rcnt_reg   <= '0;
          done_reg   <= 1'b0;
        end else begin
          state_reg  <= state_next;
          duty_reg   <= duty_next;
          target_reg <= target_next;
          rate_reg   <= rate_next;
          rcnt_reg   <= rcnt_next;
          done_reg   <= done_next;
        end
      end

      always_comb begin
        state_next  = state_reg;
        duty_next   = duty_reg;
        target_next = target_reg;
        rate_next   = rate_reg;
        rcnt_next   = rcnt_reg;
        done_next   = 1'b0;
        case (state_reg)
          S_IDLE: begin
            if (sel) begin
              if (cmd_target != duty_reg) begin
                target_next = cmd_target;
                rate_next   = cmd_rate;
                rcnt_next   = '0;
                state_next  = S_RAMP;
              end else begin
                // If the channel is already at the target, only report done.
                done_next = 1'b1;
              end
            end
          end
          S_RAMP: begin
            // step is low while ena_in=0, so a disabled ramp freezes here.
            if (step) begin
              if (rcnt_reg == rate_reg) begin
                rcnt_next = '0;
                // On entering RAMP the duty differs from the target, and the
                // ramp ends as soon as they match, so +/-1 never wraps.
                if (target_reg > duty_reg) begin
                  duty_next = duty_reg + 1'b1;
                end else begin
                  duty_next = duty_reg - 1'b1;
                end
                if (duty_next == target_reg) begin
                  state_next = S_IDLE;
                  done_next  = 1'b1;
                end
              end else begin
                rcnt_next = rcnt_reg + 1'b1;
              end
            end
          end
          default: begin
            state_next = S_IDLE;
          end
        endcase
      end

      assign busy[gi]          = (state_reg == S_RAMP);
      assign done[gi]          = done_reg;
      assign duty[gi*N +: N]   = duty_reg;
    end
  endgenerate

`ifdef PWM_FADE_STATUS_EN
  // ---------------------------------------------------------------------------
  // Sticky done flags. A new done pulse overrides a coincident clear.
  // ---------------------------------------------------------------------------
  logic [CH-1:0] flag_reg;
  logic [CH-1:0] flag_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flag_reg <= '0;
    end else begin
      flag_reg <= flag_next;
    end
  end

  always_comb begin
    flag_next = done | (flag_reg & ~{CH{irq_clr}});
  end

  assign irq = |flag_reg;
`endif

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pwm_fade_ctrl
//
// Directed test of pwm_fade_ctrl with N=8, CH=3, PRESCALE=4, RATE_W=8.
// Inputs are driven on the falling edge, and outputs are checked there too.
// This keeps all checks away from the active rising edge. When built with
// PWM_FADE_STATUS_EN, the irq flag behaviour is also checked.
// -----------------------------------------------------------------------------
module tb_pwm_fade_ctrl;

  logic        clk;
  logic        rst;
  logic        ena_in;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_ch;
  logic [7:0]  cmd_target;
  logic [7:0]  cmd_rate;
  logic        step;
  logic [2:0]  ena;
  logic [23:0] duty;
  logic [2:0]  busy;
  logic [2:0]  done;
`ifdef PWM_FADE_STATUS_EN
  logic        irq_clr;
  logic        irq;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  pwm_fade_ctrl #(
    .N        (8),
    .CH       (3),
    .PRESCALE (4),
    .RATE_W   (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ena_in     (ena_in),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_target (cmd_target),
    .cmd_rate   (cmd_rate),
    .step       (step),
    .ena        (ena),
    .duty       (duty),
    .busy       (busy),
    .done       (done)
`ifdef PWM_FADE_STATUS_EN
    ,
    .irq_clr    (irq_clr),
    .irq        (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a command on a falling edge. The command must be ready, then it
  // is held across one rising edge.
  task automatic issue(input logic [1:0] ch, input logic [7:0] tgt, input logic [7:0] rate);
    cmd_ch     = ch;
    cmd_target = tgt;
    cmd_rate   = rate;
    cmd_valid  = 1'b1;
    #1;
    check("cmd_ready", 32'(cmd_ready), 1);
    $display("cmd ch=%0d target=%0d rate=%0d", ch, tgt, rate);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) until step is visible, then let the consuming edge pass.
  task automatic next_step;
    int i = 0;
    while (!step && i < 20) begin
      @(negedge clk);
      i++;
    end
    check("step_timeout", 32'(step), 1);
    @(negedge clk);
  endtask

  initial begin
    rst        = 1'b0;
    ena_in     = 1'b1;
    cmd_valid  = 1'b0;
    cmd_ch     = 2'd0;
    cmd_target = 8'd0;
    cmd_rate   = 8'd0;
`ifdef PWM_FADE_STATUS_EN
    irq_clr    = 1'b0;
`endif

    // ---- reset state ----
    repeat (2) @(negedge clk);
    check("rst_step", 32'(step), 0);
    check("rst_ena",  32'(ena),  0);
    check("rst_duty", 32'(duty), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
`ifdef PWM_FADE_STATUS_EN
    check("rst_irq",  32'(irq),  0);
`endif
    rst = 1'b1;
    #1;
    check("ena_on", 32'(ena), 3'b111);

    // ---- prescaler: step sampled on clocks 4, 8, 12 ----
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("prescale_step", 32'(step), 32'((k % 4) == 3));
    end

    // ---- ch0 ramp 0 -> 3 at rate 0 ----
    issue(2'd0, 8'd3, 8'd0);
    check("ch0_busy", 32'(busy), 3'b001);
    for (int k = 1; k <= 3; k++) begin
      next_step();
      check("ch0_duty", 32'(duty[7:0]), k);
      check("ch0_busy_k", 32'(busy[0]), 32'(k != 3));
      check("ch0_done_k", 32'(done[0]), 32'(k == 3));
    end
    @(negedge clk);
    check("ch0_done_once", 32'(done), 0);

    // ---- ch1 ramp 0 -> 2 at rate 2, then back down to 0 ----
    issue(2'd1, 8'd2, 8'd2);
    #1;
    check("ch1_ready_busy", 32'(cmd_ready), 0);
    for (int k = 1; k <= 6; k++) begin
      next_step();
      check("ch1_up_duty", 32'(duty[15:8]), k / 3);
      check("ch1_up_done", 32'(done[1]), 32'(k == 6));
    end
    check("ch1_up_idle", 32'(busy), 0);
    issue(2'd1, 8'd0, 8'd2);
    for (int k = 1; k <= 6; k++) begin
      next_step();
      check("ch1_dn_duty", 32'(duty[15:8]), 2 - k / 3);
      check("ch1_dn_done", 32'(done[1]), 32'(k == 6));
    end

    // ---- target equal to duty, and out-of-range channel ----
    issue(2'd0, 8'd3, 8'd0);
    check("eq_busy", 32'(busy), 0);
    check("eq_done", 32'(done), 3'b001);
    @(negedge clk);
    check("eq_done_clear", 32'(done), 0);
    issue(2'd3, 8'd7, 8'd0);
    check("ch3_busy", 32'(busy), 0);
    check("ch3_done", 32'(done), 0);
    check("ch3_duty", 32'(duty), 'h000003);

    // ---- ch2 ramp paused by ena_in, then aborted by reset ----
    issue(2'd2, 8'd5, 8'd0);
    next_step();
    check("ch2_duty1", 32'(duty[23:16]), 1);
    next_step();
    check("ch2_duty2", 32'(duty[23:16]), 2);
    ena_in = 1'b0;
    #1;
    check("pause_ena", 32'(ena), 0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("pause_step", 32'(step), 0);
      check("pause_duty", 32'(duty), 'h020003);
    end
    check("pause_busy", 32'(busy), 3'b100);
    ena_in = 1'b1;
    next_step();
    check("resume_duty", 32'(duty[23:16]), 3);
    rst = 1'b0;
    #1;
    check("abort_duty", 32'(duty), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_step", 32'(step), 0);
    check("abort_ena",  32'(ena),  0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("abort_done", 32'(done), 0);
    end
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_done", 32'(done), 0);
    check("post_rst_duty", 32'(duty), 0);

    // ---- simultaneous done on ch0 and ch2, irq flag handling ----
    issue(2'd0, 8'd2, 8'd0);
    issue(2'd2, 8'd2, 8'd0);
    next_step();
    next_step();
    check("sim_done", 32'(done), 3'b101);
    check("sim_duty", 32'(duty), 'h020002);
    check("sim_busy", 32'(busy), 0);
`ifdef PWM_FADE_STATUS_EN
    check("irq_before", 32'(irq), 0);
`endif
    issue(2'd0, 8'd2, 8'd0);
    check("redo_done", 32'(done), 3'b001);
`ifdef PWM_FADE_STATUS_EN
    check("irq_set", 32'(irq), 1);
    irq_clr = 1'b1;
    @(negedge clk);
    check("irq_set_wins", 32'(irq), 1);
    @(negedge clk);
    check("irq_cleared", 32'(irq), 0);
    irq_clr = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter N, default 8: duty width per channel, matching the pwm block width.
REQ-002 Parameter CH, default 3: number of PWM channels controlled; legal range 1..4.
REQ-003 Parameter PRESCALE, default 256: clocks per step strobe; legal range >= 2.
REQ-004 Parameter RATE_W, default 8: width of the per-command ramp rate.
REQ-005 clk  in  1  single clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-007 ena_in  in  1  global run enable.
REQ-008 cmd_valid  in  1  command request.
REQ-009 cmd_ready  out  1  command accept indication.
REQ-010 cmd_ch  in  2  target channel index.
REQ-011 cmd_target  in  N  final duty value.
REQ-012 cmd_rate  in  RATE_W  extra step strobes between duty increments (0 = fastest).
REQ-013 step  out  1  one-clock strobe feeding the pwm step inputs.
REQ-014 ena  out  CH  per-channel pwm enable.
REQ-015 duty  out  CH*N  packed duty values; channel i at bits [i*N +: N].
REQ-016 busy  out  CH  channel i is ramping.
REQ-017 done  out  CH  one-clock pulse when channel i reaches its target.

Function
REQ-018 Prescaler SHALL count 0..PRESCALE-1 while ena_in=1, wrap to 0, and assert step for exactly the one cycle where the count equals PRESCALE-1.
REQ-019 With ena_in=0 the prescaler SHALL hold at 0, step SHALL be 0, ena SHALL be all 0, and all channel state SHALL freeze; commands are still accepted.
REQ-020 ena[i] SHALL equal ena_in.
REQ-021 cmd_ready SHALL be combinational: 1 if cmd_ch >= CH, else ~busy[cmd_ch].
REQ-022 A command is accepted on a rising edge with cmd_valid & cmd_ready; a command with cmd_ch >= CH SHALL be accepted and discarded with no state change.
REQ-023 Per channel FSM, states IDLE and RAMP; busy[i]=1 exactly in RAMP.
REQ-024 IDLE, accepted command with target != duty[i]: latch target and rate, clear rate counter, go RAMP on that edge.
REQ-025 IDLE, accepted command with target == duty[i]: stay IDLE, done[i]=1 for the following cycle.
REQ-026 RAMP, on each cycle with step=1: if rate counter == latched rate then duty moves 1 toward target and rate counter clears, else rate counter increments.
REQ-027 RAMP with rate=0: duty[i] SHALL move one code per step strobe.
REQ-028 The duty update that makes duty[i]==target SHALL in the same edge return the FSM to IDLE and assert done[i] for exactly the next cycle.
REQ-029 Duty arithmetic SHALL never wrap: ramps stop at target, which lies within 0..2^N-1.
REQ-030 Channels SHALL be independent; simultaneous done on several channels SHALL all be reported in the same cycle.

Reset
REQ-031 While rst=0: prescaler=0, step=0, every FSM IDLE, duty=0, rate counters=0, busy=0, done=0, ena=0.
REQ-032 Reset asserted mid-ramp SHALL abort the ramp immediately with no done pulse.
REQ-033 First step after reset release SHALL occur PRESCALE clocks after the first edge with ena_in=1.

Configuration
REQ-034 Macro PWM_FADE_STATUS_EN defined: add input irq_clr (1) and output irq (1); a sticky per-channel flag SHALL be set by done[i] and cleared on an edge with irq_clr=1 (set wins on same edge); irq = OR of flags; flags reset to 0.
REQ-035 Macro undefined: ports irq and irq_clr SHALL not exist; all other behaviour identical.

Verification
REQ-036 PRESCALE=4, ena_in=1 after reset: step high on clocks 4, 8, 12 only.
REQ-037 ch0 cmd target=3 rate=0 from duty 0: duty0 becomes 1,2,3 on successive steps; done[0] pulses once after 3; busy[0] drops in the same edge.
REQ-038 ch1 cmd target=2 rate=2: duty1 increments only every 3rd step; ramp down 2->0 after it likewise; cmd_ready low for ch1 while busy.
REQ-039 cmd target equal to current duty: no busy, done pulse one cycle after acceptance; cmd_ch=3 with CH=3: accepted, no effect.
REQ-040 Mid-ramp ena_in=0 for 10 clocks: duty, step frozen and ena=0; resume continues ramp; mid-ramp rst=0: all outputs zero, no done.
REQ-041 PWM_FADE_STATUS_EN: done on ch0 and ch2 sets irq; irq_clr coincident with new done keeps irq=1.
